// File: rtl/amp_prob.sv
// amp_prob: squares both float32 amplitudes of a single-qubit state to give
// measurement probabilities, and flags the more likely outcome. A single
// 24x24 mantissa multiplier is shared between the two squarings over two
// cycles.
//
// Handshake: prob_go is sampled only while idle; a high sample captures both
// operands and raises prob_running on the same edge. prob_upout updates one
// edge later. prob_downout and prob_outcome update on the following edge,
// where prob_done pulses for exactly one cycle and prob_running drops.
// prob_go held high starts the next run on the edge right after the done
// pulse. prob_running and prob_done are never high together.
module amp_prob (
  input  logic        clk,
  input  logic        lowrst,
  input  logic [31:0] prob_up,
  input  logic [31:0] prob_down,
  input  logic        prob_go,
  output logic [31:0] prob_upout,
  output logic [31:0] prob_downout,
  output logic        prob_outcome,
  output logic        prob_done,
  output logic        prob_running
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SQ_UP   = 2'd1,
    SQ_DOWN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        cap_en;
  logic        up_we;
  logic        down_we;

  logic [31:0] up_q;
  logic [31:0] down_q;

  // Squarer datapath signals
  logic [31:0]       sq_in;
  logic [31:0]       sq_out;
  logic [7:0]        sq_e;
  logic [47:0]       sq_p;
  logic [22:0]       sq_mant;
  logic              sq_guard;
  logic              sq_sticky;
  logic              sq_n;
  logic              sq_rnd;
  logic [23:0]       sq_mant_r;
  logic signed [9:0] sq_exp;
  logic signed [9:0] sq_exp_r;

  // State register; reset aborts any run in flight
  always_ff @(posedge clk or negedge lowrst) begin
    if (!lowrst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and per-state write enables; operand select follows the state
  always_comb begin
    state_nxt    = state;
    cap_en       = 1'b0;
    up_we        = 1'b0;
    down_we      = 1'b0;
    sq_in        = up_q;
    prob_running = (state != IDLE);
    case (state)
      IDLE: begin
        if (prob_go) begin
          cap_en    = 1'b1;
          state_nxt = SQ_UP;
        end
      end
      SQ_UP: begin
        sq_in     = up_q;
        up_we     = 1'b1;
        state_nxt = SQ_DOWN;
      end
      SQ_DOWN: begin
        sq_in     = down_q;
        down_we   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Float32 squaring: special inputs first, then 48-bit product,
  // normalise by one bit, round-to-nearest-even, clamp to inf / zero
  always_comb begin
    sq_e      = sq_in[30:23];
    sq_p      = {24'd0, 1'b1, sq_in[22:0]} * {24'd0, 1'b1, sq_in[22:0]};
    sq_mant   = 23'd0;
    sq_guard  = 1'b0;
    sq_sticky = 1'b0;
    sq_n      = 1'b0;
    if (sq_p[47]) begin
      sq_mant   = sq_p[46:24];
      sq_guard  = sq_p[23];
      sq_sticky = |sq_p[22:0];
      sq_n      = 1'b1;
    end else begin
      sq_mant   = sq_p[45:23];
      sq_guard  = sq_p[22];
      sq_sticky = |sq_p[21:0];
      sq_n      = 1'b0;
    end
    sq_exp    = $signed({1'b0, sq_e, 1'b0}) - 10'sd127 + $signed({9'd0, sq_n});
    sq_rnd    = sq_guard & (sq_sticky | sq_mant[0]);
    sq_mant_r = {1'b0, sq_mant} + {23'd0, sq_rnd};
    // A rounding carry leaves the fraction at zero and bumps the exponent
    sq_exp_r  = sq_exp + $signed({9'd0, sq_mant_r[23]});
    if (sq_e == 8'd0)
      sq_out = 32'h0000_0000;
    else if (sq_e == 8'hFF)
      sq_out = (sq_in[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
    else if (sq_exp_r >= 10'sd255)
      sq_out = 32'h7F80_0000;
    else if (sq_exp_r <= 10'sd0)
      sq_out = 32'h0000_0000;
    else
      sq_out = {1'b0, sq_exp_r[7:0], sq_mant_r[22:0]};
  end

  // Operand capture and result registers; results hold until the next run
  always_ff @(posedge clk or negedge lowrst) begin
    if (!lowrst) begin
      up_q         <= 32'd0;
      down_q       <= 32'd0;
      prob_upout   <= 32'd0;
      prob_downout <= 32'd0;
      prob_outcome <= 1'b0;
      prob_done    <= 1'b0;
    end else begin
      prob_done <= 1'b0;
      if (cap_en) begin
        up_q   <= prob_up;
        down_q <= prob_down;
      end
      if (up_we) prob_upout <= sq_out;
      if (down_we) begin
        prob_downout <= sq_out;
        // Both results are non-negative, so magnitude order is value order
        prob_outcome <= (sq_out[30:0] > prob_upout[30:0]);
        prob_done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_amp_prob.sv
// tb_amp_prob: table-driven and randomized checks of amp_prob against a
// reference model that squares via exact integer products and generic
// round-to-nearest-even.
module tb_amp_prob;

  logic        clk;
  logic        lowrst;
  logic [31:0] prob_up;
  logic [31:0] prob_down;
  logic        prob_go;
  logic [31:0] prob_upout;
  logic [31:0] prob_downout;
  logic        prob_outcome;
  logic        prob_done;
  logic        prob_running;

  int n_checks = 0;
  int n_pass   = 0;

  // {exp_up, exp_down, exp_outcome}
  logic [64:0] exp_q[$];

  typedef struct {
    logic [31:0] up;
    logic [31:0] down;
    logic [31:0] exp_up;
    logic [31:0] exp_down;
    logic        exp_out;
  } vec_t;

  vec_t vecs[10];

  amp_prob dut (
    .clk          (clk),
    .lowrst       (lowrst),
    .prob_up      (prob_up),
    .prob_down    (prob_down),
    .prob_go      (prob_go),
    .prob_upout   (prob_upout),
    .prob_downout (prob_downout),
    .prob_outcome (prob_outcome),
    .prob_done    (prob_done),
    .prob_running (prob_running)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: exact integer square of the significand, generic RNE to 24 bits
  function automatic logic [31:0] ref_square(input logic [31:0] x);
    int     e;
    int     shift;
    int     bexp;
    longint m, p, q, rem, half;
    e = int'(x[30:23]);
    if (e == 0) return 32'h0000_0000;
    if (e == 255) return (x[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
    m = longint'({1'b1, x[22:0]});
    p = m * m;
    shift = 0;
    while ((p >> shift) >= (64'd1 << 24)) shift++;
    q    = p >> shift;
    rem  = p - (q << shift);
    half = 64'd1 << (shift - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      shift++;
    end
    // value = q * 2^(shift + 2e - 300), q in [2^23, 2^24)
    bexp = 23 + shift + 2 * e - 300 + 127;
    if (bexp >= 255) return 32'h7F80_0000;
    if (bexp <= 0) return 32'h0000_0000;
    return {1'b0, bexp[7:0], q[22:0]};
  endfunction

  function automatic logic ref_outcome(input logic [31:0] a, input logic [31:0] b);
    return (b[30:0] > a[30:0]);
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[30:23] = 8'($urandom_range(40, 215));
    return v;
  endfunction

  // One complete run from idle, with go pulsed for a single cycle
  task automatic run_op(input logic [31:0] u, input logic [31:0] d,
                        input logic [31:0] eu, input logic [31:0] ed,
                        input logic eo, input string tag);
    prob_up   = u;
    prob_down = d;
    prob_go   = 1'b1;
    @(posedge clk); #1;
    prob_go   = 1'b0;
    prob_up   = $urandom;
    prob_down = $urandom;
    check({tag, " running@N"}, {31'd0, prob_running}, 32'd1);
    check({tag, " done@N"}, {31'd0, prob_done}, 32'd0);
    @(posedge clk); #1;
    check({tag, " upout"}, prob_upout, eu);
    @(posedge clk); #1;
    check({tag, " downout"}, prob_downout, ed);
    check({tag, " outcome"}, {31'd0, prob_outcome}, {31'd0, eo});
    check({tag, " done@N+2"}, {31'd0, prob_done}, 32'd1);
    check({tag, " running@N+2"}, {31'd0, prob_running}, 32'd0);
    @(posedge clk); #1;
    check({tag, " done@N+3"}, {31'd0, prob_done}, 32'd0);
  endtask

  initial begin
    logic [31:0] u, d, eu, ed;
    logic [64:0] ex;

    vecs[0] = '{32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'h3F35_04F3, 32'hBF35_04F3, 32'h3EFF_FFFF, 32'h3EFF_FFFF, 1'b0};
    vecs[2] = '{32'hBF00_0000, 32'h4000_0000, 32'h3E80_0000, 32'h4080_0000, 1'b1};
    vecs[3] = '{32'h7F00_0000, 32'h7FC0_0001, 32'h7F80_0000, 32'h7FC0_0000, 1'b1};
    vecs[4] = '{32'h1F00_0000, 32'h0040_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h3FC0_0000, 32'h3F00_0000, 32'h4010_0000, 32'h3E80_0000, 1'b0};
    vecs[6] = '{32'h2000_0000, 32'h1FFF_FFFF, 32'h0080_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h5F7F_FFFF, 32'h5F80_0000, 32'h7F7F_FFFE, 32'h7F80_0000, 1'b1};
    vecs[8] = '{32'hFF80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h3F80_0000, 1'b0};
    vecs[9] = '{32'h0000_0001, 32'hC040_0000, 32'h0000_0000, 32'h4110_0000, 1'b1};

    // Reset held for 4 cycles
    lowrst    = 1'b0;
    prob_go   = 1'b0;
    prob_up   = 32'd0;
    prob_down = 32'd0;
    repeat (4) @(posedge clk);
    #1;
    check("rst upout", prob_upout, 32'd0);
    check("rst downout", prob_downout, 32'd0);
    check("rst outcome", {31'd0, prob_outcome}, 32'd0);
    check("rst done", {31'd0, prob_done}, 32'd0);
    check("rst running", {31'd0, prob_running}, 32'd0);

    // Idle with go low: nothing moves
    lowrst    = 1'b1;
    prob_up   = 32'h4000_0000;
    prob_down = 32'h4000_0000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle done", {31'd0, prob_done}, 32'd0);
      check("idle running", {31'd0, prob_running}, 32'd0);
    end
    check("idle upout", prob_upout, 32'd0);
    check("idle downout", prob_downout, 32'd0);

    // Directed table
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].up, vecs[i].down, vecs[i].exp_up, vecs[i].exp_down,
             vecs[i].exp_out, $sformatf("vec%0d", i));

    // Randomized against the reference model
    for (int i = 0; i < 120; i++) begin
      u  = rand_operand();
      d  = rand_operand();
      if (i % 10 == 0) d = u ^ 32'h8000_0000;
      eu = ref_square(u);
      ed = ref_square(d);
      run_op(u, d, eu, ed, ref_outcome(eu, ed), $sformatf("rnd%0d u=%h d=%h", i, u, d));
    end

    // go held high across 3 back-to-back runs: done every 3rd cycle
    prob_go = 1'b1;
    for (int r = 0; r < 3; r++) begin
      u = rand_operand();
      d = rand_operand();
      prob_up   = u;
      prob_down = d;
      exp_q.push_back({ref_square(u), ref_square(d), ref_outcome(ref_square(u), ref_square(d))});
      @(posedge clk); #1;
      prob_up   = $urandom;
      prob_down = $urandom;
      check($sformatf("held%0d running@N", r), {31'd0, prob_running}, 32'd1);
      check($sformatf("held%0d done@N", r), {31'd0, prob_done}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("held%0d done@N+1", r), {31'd0, prob_done}, 32'd0);
      @(posedge clk); #1;
      ex = exp_q.pop_front();
      check($sformatf("held%0d done@N+2", r), {31'd0, prob_done}, 32'd1);
      check($sformatf("held%0d running@N+2", r), {31'd0, prob_running}, 32'd0);
      check($sformatf("held%0d upout", r), prob_upout, ex[64:33]);
      check($sformatf("held%0d downout", r), prob_downout, ex[32:1]);
      check($sformatf("held%0d outcome", r), {31'd0, prob_outcome}, {31'd0, ex[0]});
    end
    prob_go = 1'b0;
    @(posedge clk); #1;
    check("held end done", {31'd0, prob_done}, 32'd0);
    check("held end running", {31'd0, prob_running}, 32'd0);

    // go pulsed while running is ignored
    prob_up   = 32'hBF00_0000;
    prob_down = 32'h4000_0000;
    prob_go   = 1'b1;
    @(posedge clk); #1;
    prob_up   = 32'h3F80_0000;
    prob_down = 32'h0000_0000;
    @(posedge clk); #1;
    check("busy-go upout", prob_upout, 32'h3E80_0000);
    @(posedge clk); #1;
    prob_go = 1'b0;
    check("busy-go downout", prob_downout, 32'h4080_0000);
    check("busy-go outcome", {31'd0, prob_outcome}, 32'd1);
    check("busy-go done", {31'd0, prob_done}, 32'd1);
    @(posedge clk); #1;
    check("busy-go no restart", {31'd0, prob_running}, 32'd0);
    check("busy-go done clear", {31'd0, prob_done}, 32'd0);

    // Reset asserted during SQ_DOWN aborts with no done
    run_op(32'h3FC0_0000, 32'h3F00_0000, 32'h4010_0000, 32'h3E80_0000, 1'b0, "pre-abort");
    prob_up   = 32'hBF00_0000;
    prob_down = 32'h4000_0000;
    prob_go   = 1'b1;
    @(posedge clk); #1;
    prob_go = 1'b0;
    @(posedge clk); #1;
    check("abort upout before", prob_upout, 32'h3E80_0000);
    lowrst = 1'b0;
    #1;
    check("abort upout", prob_upout, 32'd0);
    check("abort downout", prob_downout, 32'd0);
    check("abort outcome", {31'd0, prob_outcome}, 32'd0);
    check("abort running", {31'd0, prob_running}, 32'd0);
    check("abort done", {31'd0, prob_done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) lowrst = 1'b1;
      check("abort no done", {31'd0, prob_done}, 32'd0);
    end
    check("abort downout held", prob_downout, 32'd0);

    // Normal run after the abort
    run_op(32'h4000_0000, 32'h3F80_0000, 32'h4080_0000, 32'h3F80_0000, 1'b0, "post-abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/amp_prob.md
# amp_prob

Squares both amplitudes of a single-qubit state (IEEE-754 single precision) to give measurement probabilities |up|² and |down|², and flags the more likely outcome. Sits directly downstream of the Hadamard stage. Its operand inputs take that stage's `hadamard_upout`/`hadamard_downout`, and its `prob_go` is driven by `hadamard_done`. A single shared 24×24 mantissa multiplier is used sequentially, so the block uses the same go/running/done handshake as the gate stages.

## Interface
- No parameters; format fixed at float32 (1/8/23, bias 127).
- `clk` in 1 — sole clock, rising edge.
- `lowrst` in 1 — reset, asynchronous, active-low.
- `prob_up` in 32 — amplitude of |0>, float32.
- `prob_down` in 32 — amplitude of |1>, float32.
- `prob_go` in 1 — start request, level-sampled while idle.
- `prob_upout` out 32 — |prob_up|², float32, registered.
- `prob_downout` out 32 — |prob_down|², float32, registered.
- `prob_outcome` out 1 — 0 if `prob_upout >= prob_downout`, else 1.
- `prob_done` out 1 — one-cycle pulse, results valid.
- `prob_running` out 1 — high while a computation is in flight.

## Operation
- States: IDLE, SQ_UP, SQ_DOWN.
- IDLE:
  - On `prob_go=1`, capture both operands into internal registers and go to SQ_UP.
  - `prob_go=0`: stay in IDLE.
- SQ_UP: multiplier operand is the captured up value; write `prob_upout`; go to SQ_DOWN.
- SQ_DOWN: multiplier operand is the captured down value; write `prob_downout`, `prob_outcome`, and `prob_done=1`; go to IDLE.
- `prob_go` is ignored outside IDLE; operands may change freely after capture.
- Squaring rules, with e = exponent field and m = {1, fraction}, 24 bits:
  - Result sign is always 0.
  - p = m·m, 48 bits. If p[47]=1, the mantissa is p[46:24] with guard p[23] and sticky |p[22:0], and n=1. Otherwise the mantissa is p[45:23] with guard p[22] and sticky |p[21:0], and n=0.
  - Biased result exponent E = 2e − 127 + n, computed in a 10-bit signed datapath.
  - Rounding: round-to-nearest-even. Mantissa carry-out increments E.
  - E ≥ 255 after rounding → 0x7F800000 (+inf).
  - E ≤ 0 → 0x00000000; no subnormal outputs.
- Special inputs, which take precedence over the rules above:
  - e=0 (zero/denormal) → 0x00000000.
  - e=255, fraction≠0 → 0x7FC00000.
  - e=255, fraction=0 → 0x7F800000.
- Outcome: unsigned compare of the two 31-bit magnitude fields (the sign is 0). A tie gives 0. NaN compares as its bit pattern.
- Outputs hold their last values until overwritten by the next run.

## Timing
- Reset values (asynchronous, on `lowrst=0`): state IDLE; `prob_upout`, `prob_downout` = 0x00000000; `prob_outcome`, `prob_done`, `prob_running` = 0.
- Reset mid-operation aborts immediately. No `prob_done` is produced for the aborted run.
- `prob_go` high at edge N, state IDLE:
  - N: capture; `prob_running`=1.
  - N+1: `prob_upout` valid.
  - N+2: `prob_downout`, `prob_outcome` valid; `prob_done`=1; `prob_running`=0.
  - N+3: `prob_done`=0.
- Latency from go to done is 2 cycles. Throughput is one run per 3 cycles.
- `prob_go` held high with `prob_done` asserted: the block is IDLE at edge N+3, so a new run starts there. Back-to-back runs are legal.
- `prob_running` and `prob_done` are never high in the same cycle.
- The multiplier path is combinational within one cycle and is not pipelined.

## Test plan
- Post-reset: hold `lowrst=0` for 4 cycles → all outputs 0. Release with `prob_go=0` for 10 cycles → outputs unchanged, `prob_done` never high.
- up=0x3F800000, down=0x00000000, single-cycle go → after 2 edges `prob_upout`=0x3F800000, `prob_downout`=0x00000000, `prob_outcome`=0, `prob_done` high exactly 1 cycle.
- up=0x3F3504F3, down=0xBF3504F3 (Hadamard of |1>) → both outputs 0x3EFFFFFF (round down, remainder below half), `prob_outcome`=0 (tie).
- up=0xBF000000, down=0x40000000 → `prob_upout`=0x3E800000, `prob_downout`=0x40800000, `prob_outcome`=1.
- Special values:
  - up=0x7F000000 (overflow), down=0x7FC00001 (NaN) → 0x7F800000 and 0x7FC00000.
  - up=0x1F000000 (underflow), down=0x00400000 (denormal) → both 0x00000000.
- Control edge cases:
  - `prob_go` held high across 3 runs → `prob_done` pulses every 3rd cycle.
  - Pulsing `prob_go` while running → ignored.
  - `lowrst` asserted in SQ_DOWN → no `prob_done`, outputs cleared immediately.
